serial_write_arbiter: RTL and testbench
=======================================

// Module: serial_write_arbiter
// PURPOSE
//  Shares one write_buffer (parallel-load, serial-out shifter) between N requesters.
//  - Picks one pending requester round-robin.
//  - Registers its word onto din/load.
//  - Times the WIDTH shift cycles, then signals completion.
//  - Sits between the master-side request logic and the serial bus line driver.
// PARAMETERS
//  N_REQ   3  number of requesters (>=2)
//  WIDTH   3  word width; must match write_buffer WIDTH
//  GUARD   1  idle cycles forced on the line between words (0..15)
// PORTS
//  clk     in   1             single clock, rising edge
//  rst     in   1             asynchronous reset, active-high
//  req     in   N_REQ         req[i] high = requester i has a word pending
//  wdata   in   N_REQ*WIDTH   word i at wdata[i*WIDTH +: WIDTH]
//  ack     out  N_REQ         one-cycle pulse: word i captured, req[i] may drop
//  done    out  N_REQ         one-cycle pulse: last bit of word i on the line
//  busy    out  1             high from grant until return to IDLE
//  load    out  1             to write_buffer.load
//  din     out  WIDTH         to write_buffer.din
//  tx_en   out  1             line-driver enable, high during SHIFT only
// BEHAVIOUR
//  Reset (async, immediate):
//  - state=IDLE; load, ack, done, busy, tx_en = 0; din = 0.
//  - RR pointer = N_REQ-1, so req[0] wins first.
//  Registered outputs; no combinational path from req to any output.
//  FSM:
//  - IDLE: at an edge with any req high, pick winner w = first set req[] searching
//    ptr+1, ptr+2, ... (mod N_REQ). Register din <= wdata[w], load=1, ack[w]=1,
//    busy=1, ptr <= w; -> LOAD. If req == 0, stay IDLE, outputs 0.
//  - LOAD: 1 cycle; write_buffer captures din at the closing edge.
//    Next: load=0, ack=0, tx_en=1, cnt=WIDTH-1; -> SHIFT.
//  - SHIFT: WIDTH cycles, cnt decrementing. done[w]=1 only in the cycle with cnt==0.
//    Exit: -> GUARD with gcnt=GUARD-1, or -> IDLE if GUARD==0. tx_en=0 on exit.
//  - GUARD: GUARD cycles, tx_en=0, busy=1. -> IDLE when gcnt==0; busy=0 in IDLE.
//  Latency:
//  - req sampled at edge E0: load/ack high in cycle E0..E1.
//  - First serial bit in cycle E1..E2.
//  - done in cycle E(WIDTH)..E(WIDTH+1).
//  Occupancy: word-to-word period = 2 + WIDTH + GUARD cycles (LOAD + SHIFT + GUARD + IDLE).
//  Boundaries:
//  - req[i] dropped before ack: request withdrawn, never granted.
//  - New reqs during LOAD/SHIFT/GUARD: ignored until IDLE, then arbitrated.
//  - wdata is sampled only at the grant edge; later changes do not affect din.
//  - Only requester = ptr: still wins once every other req is low.
//  - ptr wraps N_REQ-1 -> 0.
//  - At most one bit set in ack or done at any time.
//  - rst mid-SHIFT: tx_en and load drop immediately. The word is lost and no done is
//    issued; the requester must re-request.
// CONFIGURATION
//  SWA_FIXED_PRIORITY_EN
//  - defined: RR pointer removed; lowest-index pending req always wins.
//  - undefined: round-robin as above.
//  - All timing is identical in both builds.
// STRUCTURE
//  Package serial_bus_pkg:
//  - swa_state_t enum {IDLE, LOAD, SHIFT, GUARD}.
//  - Function/constant for counter width, $clog2(WIDTH).
//  One sub-module rr_picker (N_REQ):
//  - Inputs req, ptr; outputs onehot grant and index.
//  - Pure combinational, with the fixed-priority branch under the macro.
// TESTING  (N_REQ=3, WIDTH=3, GUARD=1, write_buffer instanced as load target)
//  1. Reset, idle: rst pulse, req=0 for 10 cycles -> all outputs 0, state stays IDLE.
//  2. Single word: req[1]=1, wdata[1]=3'b101.
//     -> Next cycle load=1, din=101, ack=3'b010.
//     -> tx_en high 3 cycles; dout serialises 101.
//     -> done[1] in 3rd shift cycle; busy low 6 cycles after grant.
//  3. Round-robin: req=3'b111 held.
//     -> Grants in order 0,1,2,0, each 6 cycles apart; din follows wdata[grant].
//     With SWA_FIXED_PRIORITY_EN defined: grants 0,0,0,...
//  4. Withdrawal and late arrival:
//     - req[2] pulses for 1 cycle during SHIFT of word 0 -> no ack[2].
//     - req[2] raised during GUARD -> granted at the first IDLE edge.
//  5. Data stability: change wdata[0] 3'b110 -> 3'b001 the cycle after ack[0]
//     -> din stays 110; serial output 110.
//  6. Reset mid-SHIFT: assert rst in 2nd shift cycle.
//     -> tx_en, load, busy 0 immediately; no done.
//     -> After release, pending req[0] is granted first (ptr reset).
//  Checkers:
//  - ack and done are onehot0.
//  - load implies a prior-cycle grant.
//  - tx_en high exactly WIDTH consecutive cycles per ack.

Source files
------------

// File: rtl/serial_bus_pkg.sv
// Shared types and sizing helpers for the serial write path.
package serial_bus_pkg;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_GUARD = 2'd3
    } swa_state_t;

    // Guard counter covers 0..15 idle cycles.
    localparam int GCNT_W = 4;

    // Width of the shift down-counter; at least one bit so WIDTH=1 still builds.
    function automatic int cnt_w(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_write_arbiter_rr_picker.sv
// Combinational requester picker.
// Default build: round-robin search starting just after ptr.
// SWA_FIXED_PRIORITY_EN defined: ptr is ignored and the lowest pending index wins.
module rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx
);

    logic [PTR_W-1:0] cand;

`ifdef SWA_FIXED_PRIORITY_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;
`endif

    // Walk the candidates once around the ring and keep the first pending one.
    always_comb begin
        grant = '0;
        idx   = '0;
`ifdef SWA_FIXED_PRIORITY_EN
        // Starting "after" the top index makes the walk begin at index 0.
        cand  = PTR_W'(N_REQ - 1);
`else
        cand  = ptr;
`endif
        for (int k = 0; k < N_REQ; k++) begin
            cand = (cand == PTR_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
            if (grant == '0 && req[cand]) begin
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/serial_write_arbiter.sv
// Shares one parallel-load / serial-out write buffer between N_REQ requesters.
// Grants a pending requester, registers its word onto din/load, times the
// WIDTH shift cycles plus GUARD idle cycles, and pulses done on the last bit.
// Build option: SWA_FIXED_PRIORITY_EN selects lowest-index-wins arbitration
// instead of round-robin; timing is identical in both builds.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, busy low; arbitrate at every edge
// S_LOAD  | load/ack high for one cycle, buffer captures din at its end
// S_SHIFT | tx_en high for WIDTH cycles, cnt counts WIDTH-1 down to 0
// S_GUARD | forced idle gap of GUARD cycles, gcnt counts down to 0
module serial_write_arbiter
    import serial_bus_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int WIDTH = 3,
    parameter int GUARD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       ack,
    output logic [N_REQ-1:0]       done,
    output logic                   busy,
    output logic                   load,
    output logic [WIDTH-1:0]       din,
    output logic                   tx_en
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = cnt_w(WIDTH);

    swa_state_t        state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GCNT_W-1:0] gcnt_q, gcnt_d;
    logic [WIDTH-1:0]  din_q, din_d;
    logic              load_q, load_d;
    logic [N_REQ-1:0]  ack_q, ack_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              busy_q, busy_d;
    logic              tx_en_q, tx_en_d;

    logic [N_REQ-1:0]  pick_grant;
    logic [PTR_W-1:0]  pick_idx;
    logic [N_REQ-1:0]  owner_oh;
    logic [WIDTH-1:0]  words [N_REQ];

    // Split the flat word bus into one word per requester.
    for (genvar g = 0; g < N_REQ; g++) begin : g_words
        assign words[g] = wdata[g*WIDTH +: WIDTH];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    assign owner_oh = N_REQ'(1) << owner_q;

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        gcnt_d  = gcnt_q;
        din_d   = din_q;
        load_d  = 1'b0;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        tx_en_d = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (req != '0) begin
                    din_d   = words[pick_idx];
                    load_d  = 1'b1;
                    ack_d   = pick_grant;
                    busy_d  = 1'b1;
                    owner_d = pick_idx;
`ifndef SWA_FIXED_PRIORITY_EN
                    ptr_d   = pick_idx;
`endif
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy_d  = 1'b1;
                tx_en_d = 1'b1;
                cnt_d   = CNT_W'(WIDTH - 1);
                // A one-bit word has its only (and last) bit in the first shift cycle.
                if (WIDTH == 1) begin
                    done_d = owner_oh;
                end
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                busy_d = 1'b1;
                if (cnt_q == '0) begin
                    if (GUARD == 0) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        gcnt_d  = GCNT_W'(GUARD - 1);
                        state_d = S_GUARD;
                    end
                end else begin
                    tx_en_d = 1'b1;
                    cnt_d   = cnt_q - 1'b1;
                    // done is registered, so raise it on the edge entering cnt==0.
                    if (cnt_q == CNT_W'(1)) begin
                        done_d = owner_oh;
                    end
                end
            end
            S_GUARD: begin
                busy_d = 1'b1;
                if (gcnt_q == '0) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset parks the pointer so requester 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= PTR_W'(N_REQ - 1);
            owner_q <= '0;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            din_q   <= '0;
            load_q  <= 1'b0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            tx_en_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            din_q   <= din_d;
            load_q  <= load_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            tx_en_q <= tx_en_d;
        end
    end

    assign ack   = ack_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign load  = load_q;
    assign din   = din_q;
    assign tx_en = tx_en_q;

endmodule

// File: tb/tb_serial_write_arbiter.sv
// Self-checking bench for serial_write_arbiter (N_REQ=3, WIDTH=3, GUARD=1).
// A small write buffer stand-in turns load/din/tx_en into a serial bit so
// the line content can be checked as well as the handshake.
module tb_serial_write_arbiter;

    localparam int N = 3;
    localparam int W = 3;
    localparam int G = 1;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic           busy;
    logic           load;
    logic [W-1:0]   din;
    logic           tx_en;

    int checks = 0;
    int errors = 0;

    serial_write_arbiter #(
        .N_REQ (N),
        .WIDTH (W),
        .GUARD (G)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .wdata (wdata),
        .ack   (ack),
        .done  (done),
        .busy  (busy),
        .load  (load),
        .din   (din),
        .tx_en (tx_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write buffer stand-in: parallel load, MSB-first shift while enabled.
    logic [W-1:0] sr;
    always @(posedge clk or posedge rst) begin
        if (rst)        sr <= '0;
        else if (load)  sr <= din;
        else if (tx_en) sr <= {sr[W-2:0], 1'b0};
    end

    // Reference model: one transaction at a time, timed by cycles since grant.
    // t=0 load/ack, t=1..W bits on the line (done at t=W), t=W+1..W+G guard.
    bit           m_active;
    int           m_t;
    int           m_w;
    int           m_ptr;
    logic [W-1:0] m_din;
    bit           auto_drop;
    int           run_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_w      = 0;
        m_ptr    = N - 1;
        m_din    = '0;
    endtask

    task automatic model_edge();
        int win;
        if (m_active) begin
            m_t++;
            if (m_t > W + G) m_active = 0;
        end else if (req != '0) begin
            win = -1;
`ifdef SWA_FIXED_PRIORITY_EN
            for (int c = 0; c < N; c++)
                if (win < 0 && req[c]) win = c;
`else
            for (int k = 1; k <= N; k++)
                if (win < 0 && req[(m_ptr + k) % N]) win = (m_ptr + k) % N;
            m_ptr = win;
`endif
            m_w      = win;
            m_din    = wdata[win*W +: W];
            m_active = 1;
            m_t      = 0;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] oh;
        logic         e_grant;
        logic         e_tx;
        logic         e_last;
        oh      = '0;
        oh[m_w] = 1'b1;
        e_grant = m_active && (m_t == 0);
        e_tx    = m_active && (m_t >= 1) && (m_t <= W);
        e_last  = m_active && (m_t == W);
        chk("load",  load,  e_grant);
        chk("ack",   ack,   e_grant ? oh : '0);
        chk("tx_en", tx_en, e_tx);
        chk("done",  done,  e_last ? oh : '0);
        chk("busy",  busy,  m_active);
        chk("din",   din,   m_din);
        chk("ack_onehot0",  $onehot0(ack),  1'b1);
        chk("done_onehot0", $onehot0(done), 1'b1);
        if (e_tx) chk("line_bit", sr[W-1], m_din[W - m_t]);
        if (tx_en) run_len++;
        else if (run_len != 0) begin
            chk("tx_run", run_len, W);
            run_len = 0;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_edge();
        @(negedge clk);
        check_outputs();
        if (auto_drop && m_active && m_t == 0) req[m_w] = 1'b0;
    endtask

    task automatic step_until_t(input int t, input string tag);
        int n;
        n = 0;
        while (!(m_active && m_t == t) && n < 40) begin
            step();
            n++;
        end
        chk(tag, (m_active && m_t == t), 1'b1);
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        model_reset();
        run_len = 0;
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst = 1'b0;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] v);
        wdata[i*W +: W] = v;
    endtask

    initial begin
        rst       = 1'b1;
        req       = '0;
        wdata     = '0;
        auto_drop = 1'b0;
        run_len   = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_outputs();
        rst = 1'b0;

        // Idle after reset.
        repeat (10) step();

        // Single word from requester 1.
        auto_drop = 1'b1;
        set_word(1, 3'b101);
        req = 3'b010;
        repeat (8) step();

        // All requesters held: rotation with distinct words.
        auto_drop = 1'b0;
        set_word(0, 3'b011);
        set_word(1, 3'b110);
        set_word(2, 3'b100);
        req = 3'b111;
        repeat (26) step();
        req = '0;
        repeat (6) step();

        // Withdrawn pulse during SHIFT, late arrival during GUARD.
        auto_drop = 1'b1;
        set_word(2, 3'b111);
        req = 3'b001;
        step_until_t(1, "wait_shift");
        req[2] = 1'b1;
        step();
        req[2] = 1'b0;
        step_until_t(W + 1, "wait_guard");
        req[2] = 1'b1;
        repeat (10) step();

        // wdata changes after grant must not reach din or the line.
        set_word(0, 3'b110);
        req = 3'b001;
        step_until_t(0, "wait_ack0");
        set_word(0, 3'b001);
        repeat (7) step();

        // Reset in the second shift cycle; requester 0 re-requests and wins first.
        req = 3'b011;
        step_until_t(2, "wait_shift2");
        mid_reset();
        req = req | 3'b001;
        repeat (16) step();

        // Randomised traffic with withdrawals, data churn and occasional resets.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            wdata = (N*W)'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
                else if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
            end
            if ($urandom_range(0, 299) == 0) mid_reset();
            else step();
        end

        req = '0;
        repeat (8) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
